dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core MEM stage and an external loader/debug port share one single-port RAM.
// Contention is fixed-priority with an anti-starvation counter, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [31:0]   e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_gnt,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          contested;
  logic          c_win;
  logic          e_win;
  logic [AW-1:0] c_waddr;
  logic [AW-1:0] e_waddr;
  logic          rd_vld_p1;
  logic          rd_own_p1;
  logic [DW-1:0] c_hold_p1;
  logic [DW-1:0] e_hold_p1;
  logic          unused_addr_bits;

  assign c_waddr          = c_addr[AW+1:2];
  assign e_waddr          = e_addr[AW+1:2];
  assign unused_addr_bits = ^{c_addr[31:AW+2], c_addr[1:0], e_addr[31:AW+2], e_addr[1:0]};
  assign contested        = c_req & e_req;

`ifdef DMEM_ARB_RR_EN
  // rr_ptr names the port that wins the next contested cycle (0 = core, 1 = external).
  logic rr_ptr;

  assign e_win = e_req & (~c_req | rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (contested) begin
      rr_ptr <= ~e_win;
    end
  end
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve;

  // External port wins contention only once it has lost STARVE_MAX contested cycles.
  assign e_win = e_req & (~c_req | (starve == STARVE_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (e_win) begin
      starve <= '0;
    end else if (contested && (starve != STARVE_LIM)) begin
      starve <= starve + 1'b1;
    end
  end
`endif

  assign c_win = c_req & ~e_win;

  // Grant stage (p0): combinational, forced idle while reset is asserted.
  assign c_gnt     = rst_n & c_win;
  assign e_gnt     = rst_n & e_win;
  assign stall     = rst_n & c_req & ~c_gnt;
  assign mem_en    = c_gnt | e_gnt;
  assign mem_we    = (c_gnt & c_we) | (e_gnt & e_we);
  assign mem_addr  = e_gnt ? e_waddr : c_waddr;
  assign mem_wdata = e_gnt ? e_wdata : c_wdata;

  // Response stage (p1): one read in flight per cycle, tagged with its owner (1 = external).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= mem_en & ~mem_we;
      rd_own_p1 <= e_gnt;
    end
  end

  assign c_rvalid = rd_vld_p1 & ~rd_own_p1;
  assign e_rvalid = rd_vld_p1 & rd_own_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_hold_p1 <= '0;
      e_hold_p1 <= '0;
    end else begin
      if (c_rvalid) c_hold_p1 <= mem_rdata;
      if (e_rvalid) e_hold_p1 <= mem_rdata;
    end
  end

  // Each port sees fresh RAM data on its rvalid cycle and keeps its last word otherwise.
  assign c_rdata = c_rvalid ? mem_rdata : c_hold_p1;
  assign e_rdata = e_rvalid ? mem_rdata : e_hold_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a single-port synchronous RAM model behind the memory port.
// Builds for fixed-priority by default, or round-robin when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [31:0]   c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          e_req, e_we, e_gnt, e_rvalid;
  logic [31:0]   e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic          stall, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_vec;
  int n_miss;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wd;
  endtask

  task automatic drive_e(input logic req, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
    e_req = req; e_we = we; e_addr = addr; e_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports read continuously for n cycles; bit i of ext_mask says the external port wins cycle i.
  // Core reads word 1 (0xA5A5A5A5), external reads word 2 (0x12345678).
  task automatic run_contest(input int n, input logic [7:0] ext_mask, input string name);
    logic pc, pe;
    pc = 1'b0; pe = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        drive_c(1'b1, 1'b0, 32'h4, '0);
        drive_e(1'b1, 1'b0, 32'h8, '0);
      end else begin
        drive_c(1'b0, 1'b0, 32'h0, '0);
        drive_e(1'b0, 1'b0, 32'h0, '0);
      end
      @(negedge clk);
      if (i < n) begin
        chk($sformatf("%s c_gnt[%0d]", name, i), c_gnt, !ext_mask[i]);
        chk($sformatf("%s e_gnt[%0d]", name, i), e_gnt, ext_mask[i]);
        chk($sformatf("%s stall[%0d]", name, i), stall, ext_mask[i]);
      end
      if (i > 0) begin
        chk($sformatf("%s c_rvalid[%0d]", name, i), c_rvalid, pc);
        chk($sformatf("%s e_rvalid[%0d]", name, i), e_rvalid, pe);
        if (pc) chk($sformatf("%s c_rdata[%0d]", name, i), c_rdata, 32'hA5A5A5A5);
        if (pe) chk($sformatf("%s e_rdata[%0d]", name, i), e_rdata, 32'h12345678);
      end
      pc = (i < n) && !ext_mask[i];
      pe = (i < n) && ext_mask[i];
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    mem_rdata = '0;
    rst_n = 1'b0;
    drive_c(1'b1, 1'b0, 32'h4, 32'h0);
    drive_e(1'b1, 1'b0, 32'h8, 32'h0);

    // Reset state with both ports requesting
    @(negedge clk);
    chk("rst c_gnt", c_gnt, 1'b0);
    chk("rst e_gnt", e_gnt, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst c_rvalid", c_rvalid, 1'b0);
    chk("rst e_rvalid", e_rvalid, 1'b0);
    chk("rst c_rdata", c_rdata, 32'h0);
    chk("rst e_rdata", e_rdata, 32'h0);
    drive_c(1'b0, 1'b0, 32'h0, '0);
    drive_e(1'b0, 1'b0, 32'h0, '0);
    tick();
    rst_n = 1'b1;

    // Core write then core read at byte 0x4
    drive_c(1'b1, 1'b1, 32'h4, 32'hA5A5A5A5);
    @(negedge clk);
    chk("cw c_gnt", c_gnt, 1'b1);
    chk("cw stall", stall, 1'b0);
    chk("cw mem_en", mem_en, 1'b1);
    chk("cw mem_we", mem_we, 1'b1);
    chk("cw mem_addr", mem_addr, 8'h01);
    chk("cw mem_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    drive_c(1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("cr c_gnt", c_gnt, 1'b1);
    chk("cr stall", stall, 1'b0);
    chk("cr mem_we", mem_we, 1'b0);
    chk("cw no rvalid", c_rvalid, 1'b0);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("cr c_rvalid", c_rvalid, 1'b1);
    chk("cr c_rdata", c_rdata, 32'hA5A5A5A5);
    chk("idle mem_en", mem_en, 1'b0);
    chk("idle mem_we", mem_we, 1'b0);
    tick();
    @(negedge clk);
    chk("cr rvalid pulse", c_rvalid, 1'b0);
    chk("cr rdata hold", c_rdata, 32'hA5A5A5A5);
    tick();

    // External write at 0x8, core reads it back
    drive_e(1'b1, 1'b1, 32'h8, 32'h12345678);
    @(negedge clk);
    chk("ew e_gnt", e_gnt, 1'b1);
    chk("ew c_gnt", c_gnt, 1'b0);
    chk("ew mem_addr", mem_addr, 8'h02);
    chk("ew mem_wdata", mem_wdata, 32'h12345678);
    tick();
    drive_e(1'b0, 1'b0, 32'h0, '0);
    drive_c(1'b1, 1'b0, 32'h8, '0);
    @(negedge clk);
    chk("cr8 c_gnt", c_gnt, 1'b1);
    chk("ew e_rvalid", e_rvalid, 1'b0);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("cr8 c_rvalid", c_rvalid, 1'b1);
    chk("cr8 c_rdata", c_rdata, 32'h12345678);
    chk("cr8 e_rvalid", e_rvalid, 1'b0);
    tick();

    // External read of word 1: core rdata holds while the external port gets the data
    drive_e(1'b1, 1'b0, 32'h4, '0);
    @(negedge clk);
    chk("er e_gnt", e_gnt, 1'b1);
    tick();
    drive_e(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("er e_rvalid", e_rvalid, 1'b1);
    chk("er e_rdata", e_rdata, 32'hA5A5A5A5);
    chk("er c_rvalid", c_rvalid, 1'b0);
    chk("er c_rdata hold", c_rdata, 32'h12345678);
    tick();

`ifdef DMEM_ARB_RR_EN
    run_contest(4, 8'b0000_1010, "rr");
`else
    // Core wins four contested cycles, external forced in the fifth, core again in the sixth
    run_contest(6, 8'b0001_0000, "fp6");
    // Counter now 1; lone core cycles must not move it
    for (int i = 0; i < 3; i++) begin
      drive_c(1'b1, 1'b0, 32'h4, '0);
      @(negedge clk);
      chk($sformatf("lone c_gnt[%0d]", i), c_gnt, 1'b1);
      tick();
    end
    drive_c(1'b0, 1'b0, 32'h0, '0);
    tick();
    run_contest(4, 8'b0000_1000, "fp4");
`endif

    // Address wrap and ignored low bits
    drive_c(1'b1, 1'b0, 32'h404, '0);
    @(negedge clk);
    chk("wrap 0x404", mem_addr, 8'h01);
    tick();
    drive_c(1'b1, 1'b0, 32'h6, '0);
    @(negedge clk);
    chk("lowbits 0x6", mem_addr, 8'h01);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, '0);
    tick();

    // Reset asserted between a read grant and its response edge
    drive_c(1'b1, 1'b0, 32'h4, '0);
    @(negedge clk);
    chk("pre-rst c_gnt", c_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst c_gnt", c_gnt, 1'b0);
    chk("mid-rst stall", stall, 1'b0);
    chk("mid-rst mem_en", mem_en, 1'b0);
    chk("mid-rst c_rdata", c_rdata, 32'h0);
    chk("mid-rst e_rdata", e_rdata, 32'h0);
    tick();
    chk("rst resp c_rvalid", c_rvalid, 1'b0);
    drive_c(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst c_rvalid", c_rvalid, 1'b0);
    chk("post-rst e_rvalid", e_rvalid, 1'b0);
    drive_c(1'b1, 1'b0, 32'h8, '0);
    @(negedge clk);
    chk("post-rst c_gnt", c_gnt, 1'b1);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk("post-rst rvalid", c_rvalid, 1'b1);
    chk("post-rst rdata", c_rdata, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
